// File: rtl/softmax_feeder_if.sv
// softmax_feeder_if: host write/start port and output stream of the softmax feeder.
interface softmax_feeder_if #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 5
);
    logic                  wr_en;
    logic [INPUTMAX-1:0]   wr_addr;
    logic [DATALENGTH-1:0] wr_data;
    logic                  start;
    logic [INPUTMAX-1:0]   n;
    logic                  busy;
    logic                  done;
    logic [DATALENGTH-1:0] dataout;
    logic                  valid;
    logic                  ready;
    logic                  first;
    logic                  last;
    logic [DATALENGTH-1:0] max_out;

    modport master (
        output wr_en, wr_addr, wr_data, start, n, ready,
        input  busy, done, dataout, valid, first, last, max_out
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, n, ready,
        output busy, done, dataout, valid, first, last, max_out
    );
endinterface

// File: rtl/softmax_feeder.sv
// softmax_feeder: buffers a logit vector, finds its max, then streams entry - max
// (saturated) so the exponent stage only ever sees non-positive operands.
module softmax_feeder #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 5
) (
    input logic              clk,
    input logic              rst,
    softmax_feeder_if.slave  bus
);
    localparam int W = DATALENGTH;

    typedef enum logic [1:0] {IDLE, SCAN, LOAD, STREAM} state_t;

    state_t                state, state_n;
    logic [W-1:0]          mem [2**INPUTMAX];
    logic [INPUTMAX-1:0]   n_q, idx, rd_addr;
    logic signed [W-1:0]   max_q, rd;
    logic signed [W:0]     diff;
    logic [W-1:0]          sat;
    logic                  hs, last_hs, scan_end;

    // In STREAM the read port looks one element ahead so the next word is ready on handshake.
    assign rd_addr  = state == STREAM ? idx + 1'b1 : idx;
    assign rd       = mem[rd_addr];
    assign diff     = {rd[W-1], rd} - {max_q[W-1], max_q};
    assign sat      = (diff[W] & ~diff[W-1]) ? {1'b1, {(W-1){1'b0}}} : diff[W-1:0];
    assign hs       = bus.valid & bus.ready;
    assign last_hs  = hs && idx == n_q - 1'b1;
    assign scan_end = idx == n_q - 1'b1;
    assign bus.busy = state != IDLE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = (bus.start && bus.n != '0) ? SCAN : IDLE;
            SCAN:   state_n = scan_end ? LOAD : SCAN;
            LOAD:   state_n = STREAM;
            STREAM: state_n = last_hs ? IDLE : STREAM;
        endcase
    end

    // Buffer is only writable in IDLE and deliberately survives reset.
    always_ff @(posedge clk)
        if (!rst && state == IDLE && bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= '0;
            idx         <= '0;
            max_q       <= '0;
            bus.dataout <= '0;
            bus.valid   <= 1'b0;
            bus.first   <= 1'b0;
            bus.last    <= 1'b0;
            bus.done    <= 1'b0;
            bus.max_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    n_q   <= bus.n;
                    idx   <= '0;
                    max_q <= '0;
                    if (bus.n == '0) begin
                        bus.done    <= 1'b1;
                        bus.max_out <= '0;
                    end
                end
                SCAN: begin
                    max_q <= (idx == '0 || rd > max_q) ? rd : max_q;
                    idx   <= scan_end ? '0 : idx + 1'b1;
                end
                LOAD: begin
                    bus.max_out <= max_q;
                    bus.dataout <= sat;
                    bus.valid   <= 1'b1;
                    bus.first   <= 1'b1;
                    bus.last    <= n_q == INPUTMAX'(1);
                end
                STREAM: if (last_hs) begin
                    bus.valid <= 1'b0;
                    bus.first <= 1'b0;
                    bus.last  <= 1'b0;
                    bus.done  <= 1'b1;
                end else if (hs) begin
                    idx         <= idx + 1'b1;
                    bus.dataout <= sat;
                    bus.first   <= 1'b0;
                    bus.last    <= idx + 1'b1 == n_q - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/softmax_feeder.md
# softmax_feeder

Stream source for the softmax datapath. A host loads a logit vector into the block's local buffer. On Start, the block scans the first N entries for their maximum. It then streams each entry minus that maximum, one word per handshake, toward the softmax core's data input. Subtracting the maximum gives the downstream exponent stage numerically stable, non-positive operands.

## Interface
- DATALENGTH, 32, word width of buffer entries and output (signed two's complement)
- INPUTMAX, 5, buffer address and N width; buffer depth 2^INPUTMAX
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock
- WrEn  in  1  buffer write strobe; honoured only when Busy=0
- WrAddr  in  INPUTMAX  buffer write address
- WrData  in  DATALENGTH  buffer write data
- Start  in  1  begin a transfer; honoured only when Busy=0
- N  in  INPUTMAX  element count, latched on accepted Start; entries 0..N-1 used
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle pulse after the final handshake, or after a N=0 Start
- Dataout  out  DATALENGTH  Buffer[k] - max, saturated
- Valid  out  1  Dataout valid
- Ready  in  1  downstream accepts Dataout when Valid&Ready at a rising edge
- First  out  1  high with element 0
- Last  out  1  high with element N-1
- MaxOut  out  DATALENGTH  maximum found by the scan; held until the next accepted Start

## Operation
- States: IDLE, SCAN, LOAD, STREAM.
- IDLE
  - WrEn writes Buffer[WrAddr] <= WrData.
  - Start with N>0: latch N, clear index and max register, go to SCAN, Busy<=1.
  - Start with N=0: stay in IDLE, Done<=1 for one cycle, no output, Busy stays 0, MaxOut<=0.
- SCAN
  - One buffer entry per cycle, read combinationally at index.
  - Running max update: first entry loads max unconditionally; later entries use signed compare.
  - Exactly N cycles; then index<=0, go to LOAD.
- LOAD (one cycle)
  - MaxOut<=max.
  - Dataout<=sat(Buffer[0]-max); Valid<=1; First<=1; Last<=(N==1).
  - Go to STREAM.
- STREAM
  - Handshake when Valid&Ready, with current element k < N-1: present element k+1 at the next edge, First<=0, Last<=(k+1==N-1).
  - Handshake on element N-1: Valid<=0, First<=0, Last<=0, Busy<=0, Done<=1, go to IDLE.
  - Without a handshake: Dataout, Valid, First and Last hold stable.
- Arithmetic
  - Difference computed at DATALENGTH+1 bits.
  - Result below -2^(DATALENGTH-1) saturates to 0x80000000.
  - The result is always ≤0, so no positive overflow is possible.
- Ignored inputs
  - WrEn and Start while Busy=1 are ignored; the buffer cannot change mid-transfer.
  - WrEn and Start together in IDLE: the write happens, and the transfer starts on the same edge. The scan begins next cycle and sees the new data.
- Reset, including mid-transfer
  - State<=IDLE.
  - Outputs go to their reset values: Busy=0, Done=0, Valid=0, First=0, Last=0, Dataout=0, MaxOut=0.
  - Buffer contents are not cleared.
  - Reset wins over Start, WrEn and any handshake on the same edge.

## Timing
- Edge numbering: accepted Start at edge E0. Busy is high after E0.
- SCAN occupies edges E1..EN.
- LOAD executes at E(N+1); Valid is high after E(N+1).
- With Ready held at 1:
  - Element k is presented after E(N+1+k) and accepted at E(N+2+k).
  - Final handshake is at E(2N+1); Done is high for the cycle after it.
  - Start-to-Done latency is 2N+1 edges.
- Each Ready=0 cycle during STREAM adds exactly one cycle.
- Earliest next Start: the edge at which Done is high. Busy is already 0 then.
- Ready is not required before Valid. Valid does not depend combinationally on Ready.

## Test plan
- Basic stream
  - Stimulus: write {3,-1,7,2} to addresses 0..3, Start with N=4, Ready=1.
  - Required: Dataout {-4,-8,0,-5}; First on element 0 and Last on element 3; MaxOut=7; Valid first high after E5; Done after E9.
- Backpressure
  - Stimulus: same vector, Ready low for 2 cycles while element 1 is presented.
  - Required: Dataout holds -8 with Valid=1 throughout; the full sequence is unchanged; Done 2 cycles later (after E11).
- Saturation
  - Stimulus: N=2, {0x7FFFFFFF, 0x80000000}.
  - Required: outputs {0, 0x80000000}; MaxOut=0x7FFFFFFF.
- Edge counts
  - N=0: Done pulse one cycle after Start; Valid never high; Busy stays 0.
  - N=1 with {-5}: single output 0 with First=Last=1; Done after E3.
- Ignored writes and Start
  - Stimulus: during SCAN and STREAM, assert WrEn to address 2 with 100, and assert Start.
  - Required: output unchanged from the basic-stream case; a later transfer still reads 7 at address 2.
- Reset mid-operation
  - Stimulus: assert Reset while element 2 is presented.
  - Required: after that edge Valid=0, Busy=0, Dataout=0, MaxOut=0, and no Done pulse. A new Start with N=4 reproduces the basic-stream results, since the buffer is retained.
